video_sig_gen: RTL

VIDEO_SIG_GEN -- requirements
Module: video_sig_gen

---
 rtl/video_sig_gen.sv | 100 ++++++++++
 1 files changed

// File: rtl/video_sig_gen.sv
// Video timing generator: raster counters, sync/active/new-frame strobes and a
// frame counter, all registered and aligned with the counters they describe.
// Optional build macro VSG_PIXEL_CE_EN adds the i_ce pixel-advance enable;
// without it every clock edge advances the raster.
module video_sig_gen #(
  parameter int unsigned ACTIVE_H_PIXELS = 1280,
  parameter int unsigned H_FRONT_PORCH   = 110,
  parameter int unsigned H_SYNC_WIDTH    = 40,
  parameter int unsigned H_BACK_PORCH    = 220,
  parameter int unsigned ACTIVE_LINES    = 720,
  parameter int unsigned V_FRONT_PORCH   = 5,
  parameter int unsigned V_SYNC_WIDTH    = 5,
  parameter int unsigned V_BACK_PORCH    = 20,
  parameter int unsigned FPS             = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
`ifdef VSG_PIXEL_CE_EN
  input  logic        i_ce,
`endif
  output logic [10:0] o_hcount,
  output logic [9:0]  o_vcount,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_ad,
  output logic        o_nf,
  output logic [5:0]  o_fc
);

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int unsigned FW = 6;

  localparam int unsigned TOTAL_H  = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int unsigned TOTAL_V  = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
  localparam int unsigned HS_START = ACTIVE_H_PIXELS + H_FRONT_PORCH;
  localparam int unsigned HS_END   = HS_START + H_SYNC_WIDTH;
  localparam int unsigned VS_START = ACTIVE_LINES + V_FRONT_PORCH;
  localparam int unsigned VS_END   = VS_START + V_SYNC_WIDTH;

  logic          advance_c;
  logic          h_wrap_c;
  logic          v_wrap_c;
  logic [HW-1:0] h_next_c;
  logic [VW-1:0] v_next_c;
  logic          hs_next_c;
  logic          vs_next_c;
  logic          ad_next_c;
  logic          nf_next_c;
  logic [FW-1:0] fc_next_c;

  // Pixel advance qualifier
`ifdef VSG_PIXEL_CE_EN
  assign advance_c = i_ce;
`else
  assign advance_c = 1'b1;
`endif

  // Next raster position and the strobes decoded from it, so registered
  // strobes line up with the registered counters they describe
  always_comb begin
    h_wrap_c  = (o_hcount == HW'(TOTAL_H - 1));
    v_wrap_c  = (o_vcount == VW'(TOTAL_V - 1));
    h_next_c  = h_wrap_c ? '0 : o_hcount + HW'(1);
    v_next_c  = o_vcount;
    if (h_wrap_c) begin
      v_next_c = v_wrap_c ? '0 : o_vcount + VW'(1);
    end
    hs_next_c = (h_next_c >= HW'(HS_START)) && (h_next_c < HW'(HS_END));
    vs_next_c = (v_next_c >= VW'(VS_START)) && (v_next_c < VW'(VS_END));
    ad_next_c = (h_next_c < HW'(ACTIVE_H_PIXELS)) && (v_next_c < VW'(ACTIVE_LINES));
    nf_next_c = (h_next_c == HW'(ACTIVE_H_PIXELS)) && (v_next_c == VW'(ACTIVE_LINES));
    fc_next_c = o_fc;
    if (nf_next_c) begin
      fc_next_c = (o_fc == FW'(FPS - 1)) ? '0 : o_fc + FW'(1);
    end
  end

  // Raster state; reset parks on the last pixel so the first advance lands on (0,0)
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hcount <= HW'(TOTAL_H - 1);
      o_vcount <= VW'(TOTAL_V - 1);
      o_hs     <= 1'b0;
      o_vs     <= 1'b0;
      o_ad     <= 1'b0;
      o_nf     <= 1'b0;
      o_fc     <= '0;
    end else if (advance_c) begin
      o_hcount <= h_next_c;
      o_vcount <= v_next_c;
      o_hs     <= hs_next_c;
      o_vs     <= vs_next_c;
      o_ad     <= ad_next_c;
      o_nf     <= nf_next_c;
      o_fc     <= fc_next_c;
    end
  end

endmodule
